traffic_phase_controller: RTL
=============================

// Module: traffic_phase_controller
// PURPOSE
//  Parametrised N-approach traffic-signal sequencer with per-approach car demand, latched pedestrian request,
//  programmable phase timers, round-robin service and all-red clearance. It sits between raw sensor/button
//  inputs and the lamp drivers and emits one-hot lamp codes per approach plus walk and status outputs.
// PARAMETERS
//  N_APPR       2   number of approaches (>=2)
//  GREEN_MIN    8   minimum green cycles before yielding (>=1)
//  YELLOW_TIME  3   yellow cycles (>=1)
//  ALLRED_TIME  2   all-red clearance cycles (>=1)
//  PED_TIME     6   walk-phase cycles (>=1)
//  FLASH_HALF   4   flash half-period cycles (used only with TLC_FLASH_EN)
//  CNT_W        8   phase timer width; every *_TIME/GREEN_MIN/FLASH_HALF value must be < 2**CNT_W
// PORTS
//  clk                input   1          single clock, rising edge
//  reset              input   1          asynchronous, active-high
//  car_sensor         input   N_APPR     per-approach vehicle presence, level
//  pedestrian_button  input   1          pedestrian request, level
//  flash_req          input   1          maintenance flash request (present only with TLC_FLASH_EN)
//  lights             output  3*N_APPR   approach i at [3i+2:3i]; RED=001 YELLOW=010 GREEN=100
//  walk               output  1          pedestrian walk lamp
//  phase              output  3          current state code (tlc_pkg)
//  active_appr        output  AW         approach served or last served; AW=max(1,$clog2(N_APPR))
// BEHAVIOUR
//  - Moore machine; all outputs registered, update on the same edge as the state.
//  - Reset: state ALL_RED, timer=0, active_appr=N_APPR-1 (the first grant search starts at 0), car_req=0,
//    ped_pend=0, every lights field RED, walk=0. Reset mid-phase aborts immediately to this state.
//  - timer clears to 0 on every state change and increments otherwise, saturating at 2**CNT_W-1.
//  - car_req[i] is set while car_sensor[i]=1 and cleared on entry to GREEN(i). Set wins if both occur on one edge.
//  - ped_pend is set while pedestrian_button=1 outside WALK and cleared on entry to WALK.
//    Presses during WALK are ignored.
//  - ALL_RED: all RED. When timer==ALLRED_TIME-1, the next state is chosen by priority:
//    ped_pend -> WALK; otherwise any car_req -> GREEN(g), where g is the first requesting approach
//    searching active_appr+1, +2, ... (mod N_APPR); otherwise stay in ALL_RED (idle rest).
//    Requests arriving while idle are evaluated every cycle.
//  - GREEN(a): lights[a]=GREEN, others RED.
//    -> YELLOW when timer>=GREEN_MIN-1 AND (car_req of any other approach OR ped_pend).
//    With no competing demand the controller rests in green indefinitely.
//  - YELLOW(a): lights[a]=YELLOW, others RED; -> ALL_RED when timer==YELLOW_TIME-1.
//  - WALK: all RED, walk=1 for exactly PED_TIME cycles, then -> ALL_RED. active_appr is unchanged.
//  - Simultaneous car and pedestrian demand at the ALL_RED decision: pedestrian wins.
//    A car on the active approach does not retain the green past competing demand.
//  - Invariant: at most one approach is non-RED at any cycle; walk=1 only when all approaches are RED.
// CONFIGURATION
//  TLC_FLASH_EN defined: adds the flash_req port and a FLASH state.
//   - flash_req=1 is honoured only at the ALL_RED decision point, above pedestrian priority.
//   - In FLASH, all approaches toggle between YELLOW and 000 every FLASH_HALF cycles, starting with YELLOW;
//     walk=0; car_req and ped_pend keep latching.
//   - When flash_req=0 is sampled, the next state is ALL_RED with timer=0.
//  TLC_FLASH_EN undefined: no flash_req port, no FLASH state; its phase code is never produced.
// STRUCTURE
//  - tlc_pkg holds: lamp codes RED/YELLOW/GREEN; the state enum ALL_RED=0, GREEN=1, YELLOW=2, WALK=3, FLASH=4
//    (3-bit, phase output encoding).
//  - tlc_rr_arbiter: combinational round-robin picker (req[N_APPR], last[AW] -> grant_valid, grant_idx[AW]).
//    It is used for the ALL_RED decision. The controller FSM, timer and request latches live in the top module.
// TESTING  (defaults unless noted)
//  1. Reset then idle, no inputs -> phase stays ALL_RED, lights=6'b001001, walk=0 indefinitely.
//  2. car_sensor=2'b01 one cycle after reset -> GREEN(0) entered 2 cycles later. Then car_sensor=2'b10 ->
//     approach 0 gets 8 green cycles total, then 3 YELLOW, 2 ALL_RED, then lights=6'b100001.
//  3. pedestrian_button and car_sensor=2'b10 pulsed together while in YELLOW(0) -> after clearance WALK
//     for 6 cycles (walk=1, all RED), then 2 ALL_RED, then GREEN(1).
//  4. car_sensor=2'b11 held with N_APPR=3 (car_sensor=3'b011) -> grants alternate 0,1,0,1 and approach 2
//     is never granted; no two approaches are non-RED in the same cycle.
//  5. Assert reset during GREEN(1) timer=4 -> next cycle all RED, phase=ALL_RED, requests cleared.
//  6. TLC_FLASH_EN, flash_req=1 in GREEN(0) -> normal yellow/all-red, then FLASH toggling 010/000 every
//     4 cycles; flash_req=0 -> ALL_RED with timer=0.

Source files
------------

// File: rtl/tlc_pkg.sv
// Shared lamp codes and controller state encoding (the state value doubles as the phase output).
// Optional maintenance flash is built when TLC_FLASH_EN is defined.
package tlc_pkg;

    localparam logic [2:0] LAMP_OFF    = 3'b000;
    localparam logic [2:0] LAMP_RED    = 3'b001;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_GREEN  = 3'b100;

    typedef enum logic [2:0] {
        ST_ALL_RED = 3'd0,
        ST_GREEN   = 3'd1,
        ST_YELLOW  = 3'd2,
        ST_WALK    = 3'd3,
        ST_FLASH   = 3'd4
    } tlc_state_e;

endpackage

// File: rtl/tlc_rr_arbiter.sv
// Combinational round-robin picker: first set request strictly after last_i, wrapping modulo N.
// Used by the controller at the all-red decision point.
module tlc_rr_arbiter #(
    parameter int N  = 2,
    parameter int AW = 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [AW-1:0] last_i,
    output logic          grant_valid_o,
    output logic [AW-1:0] grant_idx_o
);

    logic [N-1:0] rot;

    always_comb begin
        // rot[j] is the request of approach (last_i + 1 + j) mod N
        rot           = N'({req_i, req_i} >> (32'(last_i) + 1));
        grant_valid_o = |rot;
        grant_idx_o   = '0;
        for (int j = N - 1; j >= 0; j--) begin
            if (rot[j]) begin
                grant_idx_o = AW'((32'(last_i) + 1 + j) % N);
            end
        end
    end

endmodule

// File: rtl/traffic_phase_controller.sv
// N-approach traffic sequencer: round-robin greens, latched pedestrian walk, all-red clearance.
// Define TLC_FLASH_EN to add the flash_req input and the maintenance FLASH state.
module traffic_phase_controller
    import tlc_pkg::*;
#(
    parameter int N_APPR      = 2,
    parameter int GREEN_MIN   = 8,
    parameter int YELLOW_TIME = 3,
    parameter int ALLRED_TIME = 2,
    parameter int PED_TIME    = 6,
    parameter int FLASH_HALF  = 4,
    parameter int CNT_W       = 8,
    localparam int AW         = (N_APPR > 1) ? $clog2(N_APPR) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_APPR-1:0]     car_sensor,
    input  logic                  pedestrian_button,
`ifdef TLC_FLASH_EN
    input  logic                  flash_req,
`endif
    output logic [3*N_APPR-1:0]   lights,
    output logic                  walk,
    output logic [2:0]            phase,
    output logic [AW-1:0]         active_appr
);

    tlc_state_e          state_q, state_d;
    logic [CNT_W-1:0]    timer_q, timer_d;
    logic [AW-1:0]       appr_q, appr_d;
    logic [N_APPR-1:0]   car_req_q, car_req_d;
    logic                ped_q, ped_d;
    logic [3*N_APPR-1:0] lights_q, lights_d;
    logic                walk_q, walk_d;
    logic                gnt_valid;
    logic [AW-1:0]       gnt_idx;
    logic [N_APPR-1:0]   other_req;
`ifdef TLC_FLASH_EN
    logic                flash_on_q, flash_on_d;
`endif

    tlc_rr_arbiter #(.N(N_APPR), .AW(AW)) u_arb (
        .req_i         (car_req_q),
        .last_i        (appr_q),
        .grant_valid_o (gnt_valid),
        .grant_idx_o   (gnt_idx)
    );

    assign other_req = car_req_q & ~(N_APPR'(1) << appr_q);

    always_comb begin
        state_d = state_q;
        appr_d  = appr_q;
        case (state_q)
            ST_ALL_RED: begin
                // >= rather than == so an idle rest keeps re-evaluating demand every cycle
                if (timer_q >= CNT_W'(ALLRED_TIME - 1)) begin
`ifdef TLC_FLASH_EN
                    if (flash_req) state_d = ST_FLASH;
                    else
`endif
                    if (ped_q) state_d = ST_WALK;
                    else if (gnt_valid) begin
                        state_d = ST_GREEN;
                        appr_d  = gnt_idx;
                    end
                end
            end
            ST_GREEN: begin
                if (timer_q >= CNT_W'(GREEN_MIN - 1) && ((|other_req) || ped_q)) state_d = ST_YELLOW;
            end
            ST_YELLOW: begin
                if (timer_q == CNT_W'(YELLOW_TIME - 1)) state_d = ST_ALL_RED;
            end
            ST_WALK: begin
                if (timer_q == CNT_W'(PED_TIME - 1)) state_d = ST_ALL_RED;
            end
`ifdef TLC_FLASH_EN
            ST_FLASH: begin
                if (!flash_req) state_d = ST_ALL_RED;
            end
`endif
            default: state_d = ST_ALL_RED;
        endcase

        if (state_d != state_q) timer_d = '0;
`ifdef TLC_FLASH_EN
        // The flash timer restarts each half period so the toggle never stalls on saturation
        else if (state_q == ST_FLASH && timer_q == CNT_W'(FLASH_HALF - 1)) timer_d = '0;
`endif
        else if (timer_q != '1) timer_d = timer_q + 1'b1;
        else timer_d = timer_q;

`ifdef TLC_FLASH_EN
        flash_on_d = 1'b0;
        if (state_d == ST_FLASH) begin
            if (state_q != ST_FLASH) flash_on_d = 1'b1;
            else if (timer_q == CNT_W'(FLASH_HALF - 1)) flash_on_d = ~flash_on_q;
            else flash_on_d = flash_on_q;
        end
`endif

        // Clear on entry is applied first so a sensor/button still active on that edge re-latches
        car_req_d = car_req_q;
        if (state_d == ST_GREEN && state_q != ST_GREEN) car_req_d[appr_d] = 1'b0;
        car_req_d = car_req_d | car_sensor;

        ped_d = ped_q;
        if (state_d == ST_WALK && state_q != ST_WALK) ped_d = 1'b0;
        if (pedestrian_button && state_q != ST_WALK) ped_d = 1'b1;

        walk_d   = (state_d == ST_WALK);
        lights_d = '0;
        for (int i = 0; i < N_APPR; i++) begin
            lights_d[3*i +: 3] = LAMP_RED;
            if (appr_d == AW'(i) && state_d == ST_GREEN)  lights_d[3*i +: 3] = LAMP_GREEN;
            if (appr_d == AW'(i) && state_d == ST_YELLOW) lights_d[3*i +: 3] = LAMP_YELLOW;
`ifdef TLC_FLASH_EN
            if (state_d == ST_FLASH) lights_d[3*i +: 3] = flash_on_d ? LAMP_YELLOW : LAMP_OFF;
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_ALL_RED;
            timer_q    <= '0;
            appr_q     <= AW'(N_APPR - 1);
            car_req_q  <= '0;
            ped_q      <= 1'b0;
            lights_q   <= {N_APPR{LAMP_RED}};
            walk_q     <= 1'b0;
`ifdef TLC_FLASH_EN
            flash_on_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            appr_q     <= appr_d;
            car_req_q  <= car_req_d;
            ped_q      <= ped_d;
            lights_q   <= lights_d;
            walk_q     <= walk_d;
`ifdef TLC_FLASH_EN
            flash_on_q <= flash_on_d;
`endif
        end
    end

    assign lights      = lights_q;
    assign walk        = walk_q;
    assign phase       = state_q;
    assign active_appr = appr_q;

endmodule
